register_bank: RTL and testbench

Integer register file for the single-cycle datapath, directly upstream of the ALU. It holds 2^ADDR_WIDTH general-purpose registers, with register 0 hardwired to zero. It provides two combinational read ports: `readData1` feeds the ALU first operand, and `readData2` feeds the operand mux and the store path. One synchronous write port is committed on the rising clock edge, and a third read-only debug port lets the bench inspect state.

---
 rtl/register_bank.sv | 64 ++++++
 tb/tb_register_bank.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// register_bank : 2^ADDR_WIDTH x DATA_WIDTH integer register file with r0 reading zero.
// Rev 1.0
// ---------------------------------------------------------------------------
module register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  regWrite,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    input  logic [ADDR_WIDTH-1:0] writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] debugRegister,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic [DATA_WIDTH-1:0] debugData,
    output logic [15:0]           writeCount
);

    localparam int          NUM_REGS  = 1 << ADDR_WIDTH;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [15:0]           writeCount_q;
    logic [15:0]           writeCount_d;
    logic                  write_en;

    // Writes aimed at r0 are dropped entirely, including from the count.
    assign write_en = regWrite && (writeRegister != '0);

    always_comb begin
        writeCount_d = writeCount_q;
        if (write_en && (writeCount_q != COUNT_MAX)) begin
            writeCount_d = writeCount_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            writeCount_q <= '0;
        end else begin
            if (write_en) begin
                regs_q[writeRegister] <= writeData;
            end
            writeCount_q <= writeCount_d;
        end
    end

    // Reads come straight from storage: no bypass, since writeData is derived
    // from these outputs through the ALU and a bypass would close a loop.
    assign readData1  = (readRegister1 == '0) ? '0 : regs_q[readRegister1];
    assign readData2  = (readRegister2 == '0) ? '0 : regs_q[readRegister2];
    assign debugData  = (debugRegister == '0) ? '0 : regs_q[debugRegister];
    assign writeCount = writeCount_q;

endmodule
`default_nettype wire

// File: tb/tb_register_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_register_bank : randomized + directed scoreboard bench for register_bank.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_register_bank;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clock         = 1'b0;
    logic          resetN        = 1'b1;
    logic          regWrite      = 1'b0;
    logic [AW-1:0] readRegister1 = '0;
    logic [AW-1:0] readRegister2 = '0;
    logic [AW-1:0] writeRegister = '0;
    logic [DW-1:0] writeData     = '0;
    logic [AW-1:0] debugRegister = '0;
    logic [DW-1:0] readData1;
    logic [DW-1:0] readData2;
    logic [DW-1:0] debugData;
    logic [15:0]   writeCount;

    register_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock         (clock),
        .resetN        (resetN),
        .regWrite      (regWrite),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .debugRegister (debugRegister),
        .readData1     (readData1),
        .readData2     (readData2),
        .debugData     (debugData),
        .writeCount    (writeCount)
    );

    always #5 clock = ~clock;

    // Reference model: plain array plus an integer write counter.
    logic [DW-1:0] model [NR];
    int            model_count;

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) model[i] = '0;
        model_count = 0;
    endfunction

    function automatic void model_write(input logic we, input logic [AW-1:0] wa,
                                        input logic [DW-1:0] wd);
        if (we && wa != 0) begin
            model[wa] = wd;
            if (model_count < 65535) model_count = model_count + 1;
        end
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] idx);
        return (idx == 0) ? '0 : model[idx];
    endfunction

    // Scoreboard: port 0=readData1, 1=readData2, 2=debugData, 3=writeCount.
    typedef struct {
        string       name;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    event sample_ev;
    int   passed = 0;
    int   total  = 0;

    initial begin
        forever begin
            @(sample_ev);
            while (sbq.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = sbq.pop_front();
                case (e.port)
                    0:       act = readData1;
                    1:       act = readData2;
                    2:       act = debugData;
                    default: act = {16'h0, writeCount};
                endcase
                total++;
                if (act === e.exp) passed++;
                else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string n, input int port, input logic [31:0] e);
        sbq.push_back('{n, port, e});
    endtask

    task automatic sample();
        ->sample_ev;
        #1;
    endtask

    // Point the read ports, then queue model-derived expectations for all outputs.
    task automatic read_check(input string n, input logic [AW-1:0] i1,
                              input logic [AW-1:0] i2, input logic [AW-1:0] id);
        readRegister1 = i1;
        readRegister2 = i2;
        debugRegister = id;
        #1;
        expect_val({n, ".rd1"}, 0, model_read(i1));
        expect_val({n, ".rd2"}, 1, model_read(i2));
        expect_val({n, ".dbg"}, 2, model_read(id));
        expect_val({n, ".cnt"}, 3, {16'h0, 16'(model_count)});
        sample();
    endtask

    task automatic do_write(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        @(negedge clock);
        regWrite      = we;
        writeRegister = wa;
        writeData     = wd;
        @(posedge clock);
        model_write(we, wa, wd);
        #1 regWrite = 1'b0;
    endtask

    task automatic pulse_reset_and_check(input string n);
        @(negedge clock);
        #1 resetN = 1'b0;
        #1;
        expect_val({n, ".rd1"}, 0, 32'h0);
        expect_val({n, ".rd2"}, 1, 32'h0);
        expect_val({n, ".dbg"}, 2, 32'h0);
        expect_val({n, ".cnt"}, 3, 32'h0);
        sample();
        resetN = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          we;
        model_reset();

        // Reset held over edges while a write is attempted; the write must be ignored.
        #2 resetN = 1'b0;
        regWrite = 1'b1; writeRegister = 5'd4; writeData = 32'hCAFEF00D;
        repeat (2) @(posedge clock);
        @(negedge clock);
        regWrite = 1'b0;
        resetN   = 1'b1;
        for (int i = 0; i < NR; i++) read_check("reset_sweep", AW'(i), AW'(NR - 1 - i), AW'(i));

        // Basic write then read.
        do_write(1'b1, 5'd5,  32'hDEADBEEF);
        do_write(1'b1, 5'd31, 32'h00000007);
        read_check("wr_rd", 5'd5, 5'd31, 5'd5);

        // Register 0 is never written and never counted.
        do_write(1'b1, 5'd0, 32'hFFFFFFFF);
        read_check("r0_write", 5'd0, 5'd0, 5'd0);
        do_write(1'b1, 5'd3, 32'h0000A5A5);
        do_write(1'b0, 5'd3, 32'h00001234);
        read_check("we_low", 5'd3, 5'd3, 5'd3);

        // No bypass: the old value is visible until the edge commits the new one.
        do_write(1'b1, 5'd9, 32'h00000011);
        @(negedge clock);
        readRegister1 = 5'd9; readRegister2 = 5'd9; debugRegister = 5'd9;
        regWrite = 1'b1; writeRegister = 5'd9; writeData = 32'h00000022;
        #1;
        expect_val("nobypass.pre", 0, 32'h00000011);
        expect_val("nobypass.pre_dbg", 2, 32'h00000011);
        sample();
        @(posedge clock);
        model_write(1'b1, 5'd9, 32'h00000022);
        #1 regWrite = 1'b0;
        read_check("nobypass.post", 5'd9, 5'd9, 5'd9);

        // Randomized traffic: check pre-edge (old state) and post-edge (new state).
        for (int c = 0; c < 300; c++) begin
            we = ($urandom_range(0, 3) != 0);
            wa = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(0, NR - 1));
            wd = $urandom();
            @(negedge clock);
            regWrite = we; writeRegister = wa; writeData = wd;
            read_check("rand.pre", ($urandom_range(0, 1) != 0) ? wa : AW'($urandom_range(0, NR - 1)),
                       AW'($urandom_range(0, NR - 1)), wa);
            @(posedge clock);
            model_write(we, wa, wd);
            #1 regWrite = 1'b0;
            read_check("rand.post", wa, AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)));
        end

        // Asynchronous reset between edges after filling r1..r31 with their index.
        for (int i = 1; i < NR; i++) do_write(1'b1, AW'(i), DW'(i));
        read_check("fill", 5'd7, 5'd31, 5'd1);
        readRegister1 = 5'd7; readRegister2 = 5'd31; debugRegister = 5'd1;
        pulse_reset_and_check("async_rst");
        for (int i = 0; i < NR; i++) read_check("post_rst_sweep", AW'(i), AW'(i), AW'(i));

        // Counter saturation: 65537 writes alternating r1 and r2.
        for (int i = 0; i < 65534; i++) do_write(1'b1, (i % 2 == 0) ? 5'd1 : 5'd2, DW'(i));
        read_check("sat.fffe", 5'd1, 5'd2, 5'd0);
        for (int i = 65534; i < 65537; i++) begin
            do_write(1'b1, (i % 2 == 0) ? 5'd1 : 5'd2, DW'(i));
            read_check("sat.hold", 5'd1, 5'd2, 5'd2);
        end
        expect_val("sat.final_cnt", 3, 32'h0000FFFF);
        expect_val("sat.r1_last", 0, 32'd65536);
        expect_val("sat.r2_last", 1, 32'd65535);
        sample();

        total++;
        if (writeCount === 16'hFFFF) passed++;
        else $display("FAIL sat.direct_cnt: got %h expected ffff", writeCount);
        total++;
        if (readData1 === 32'd65536) passed++;
        else $display("FAIL sat.direct_rd1: got %h expected %h", readData1, 32'd65536);
        total++;
        if (readData2 === 32'd65535) passed++;
        else $display("FAIL sat.direct_rd2: got %h expected %h", readData2, 32'd65535);
        total++;
        if (debugData === 32'd65535) passed++;
        else $display("FAIL sat.direct_dbg: got %h expected %h", debugData, 32'd65535);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
